// File: rtl/up_counter_scan_pkg.sv
// Shared types and pure next-state logic for the scan-capable up-counter.
package up_counter_scan_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 64;

    typedef enum logic [1:0] {
        MODE_RESET,
        MODE_SCAN,
        MODE_COUNT,
        MODE_HOLD
    } mode_e;

    typedef logic [MAX_WIDTH-1:0] count_t;

    // The caller truncates the result to its own width.
    // Shifting left and adding one are both width-agnostic once truncated.
    function automatic count_t next_count(input count_t cur, input logic scan_in, input mode_e mode);
        count_t nxt;
        case (mode)
            MODE_RESET: nxt = '0;
            MODE_SCAN:  nxt = {cur[MAX_WIDTH-2:0], scan_in};
            MODE_COUNT: nxt = cur + count_t'(1);
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/up_counter_scan_if.sv
// Scan/count control and observation bundle for up_counter_scan.
// Optional bWrap signal present when UP_COUNTER_SCAN_WRAP_EN is defined.
interface up_counter_scan_if
    import up_counter_scan_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             aScanEn;
    logic             bScanIn;
    logic             aIncrement;
    logic [WIDTH-1:0] bCount;
    logic             bScanOut;
`ifdef UP_COUNTER_SCAN_WRAP_EN
    logic             bWrap;

    modport master (output aScanEn, bScanIn, aIncrement, input bCount, bScanOut, bWrap);
    modport slave  (input aScanEn, bScanIn, aIncrement, output bCount, bScanOut, bWrap);
`else
    modport master (output aScanEn, bScanIn, aIncrement, input bCount, bScanOut);
    modport slave  (input aScanEn, bScanIn, aIncrement, output bCount, bScanOut);
`endif

endinterface

// File: rtl/up_counter_scan.sv
// WIDTH-bit up-counter whose count register doubles as an MSB-first scan chain.
// Define UP_COUNTER_SCAN_WRAP_EN to add the registered one-cycle bWrap flag.
module up_counter_scan
    import up_counter_scan_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                BrdClk,
    input  logic                bReset,
    up_counter_scan_if.slave    bus
);

    mode_e            mode;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Per-edge action: reset > scan > increment > hold.
    always_comb begin
        mode = MODE_HOLD;
        if (bReset) begin
            mode = MODE_RESET;
        end else if (bus.aScanEn) begin
            mode = MODE_SCAN;
        end else if (bus.aIncrement) begin
            mode = MODE_COUNT;
        end
    end

    always_comb begin
        count_d = WIDTH'(next_count(MAX_WIDTH'(count_q), bus.bScanIn, mode));
    end

`ifdef UP_COUNTER_SCAN_WRAP_EN
    logic wrap_q;
    logic wrap_d;

    always_comb begin
        wrap_d = (mode == MODE_COUNT) && (count_q == '1);
    end
`endif

    always_ff @(posedge BrdClk) begin
        if (bReset) begin
            count_q <= '0;
`ifdef UP_COUNTER_SCAN_WRAP_EN
            wrap_q  <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
`ifdef UP_COUNTER_SCAN_WRAP_EN
            wrap_q  <= wrap_d;
`endif
        end
    end

    assign bus.bCount   = count_q;
    assign bus.bScanOut = count_q[WIDTH-1];
`ifdef UP_COUNTER_SCAN_WRAP_EN
    assign bus.bWrap    = wrap_q;
`endif

endmodule

// File: tb/tb_up_counter_scan.sv
// Self-checking bench for up_counter_scan: directed scenarios plus random stimulus vs an arithmetic model.
module tb_up_counter_scan;

    localparam int unsigned W   = 4;
    localparam int unsigned MOD = 1 << W;

    logic BrdClk = 1'b0;
    logic bReset;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int unsigned m_count = 0;
    bit          m_wrap  = 1'b0;

    up_counter_scan_if #(.WIDTH(W)) bus ();

    up_counter_scan #(.WIDTH(W)) dut (
        .BrdClk (BrdClk),
        .bReset (bReset),
        .bus    (bus.slave)
    );

    always #5 BrdClk = ~BrdClk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One edge: apply inputs, advance the model, check every output just after the edge.
    task automatic step(input string tag, input bit r, input bit se, input bit si, input bit inc);
        bReset         = r;
        bus.aScanEn    = se;
        bus.bScanIn    = si;
        bus.aIncrement = inc;
        @(posedge BrdClk);
        if (r) begin
            m_count = 0;
            m_wrap  = 1'b0;
        end else if (se) begin
            m_count = ((m_count * 2) + int'(si)) % MOD;
            m_wrap  = 1'b0;
        end else if (inc) begin
            m_wrap  = (m_count == MOD - 1);
            m_count = (m_count + 1) % MOD;
        end else begin
            m_wrap  = 1'b0;
        end
        #1;
        check_eq({tag, ".count"}, 32'(bus.bCount), 32'(m_count));
        check_eq({tag, ".scan_out"}, 32'(bus.bScanOut), 32'((m_count >> (W - 1)) & 1));
`ifdef UP_COUNTER_SCAN_WRAP_EN
        check_eq({tag, ".wrap"}, 32'(bus.bWrap), 32'(m_wrap));
`endif
    endtask

    initial begin
        bit [3:0] scan_pat;
        bReset         = 1'b0;
        bus.aScanEn    = 1'b0;
        bus.bScanIn    = 1'b0;
        bus.aIncrement = 1'b0;

        // Reset held for two edges with arbitrary other inputs
        for (int i = 0; i < 2; i++) begin
            step("reset", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        check_eq("reset_zero", 32'(bus.bCount), 32'd0);

        for (int i = 0; i < 10; i++) step("count", 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("count_ten", 32'(bus.bCount), 32'd10);

        scan_pat = 4'b0110;
        for (int i = 3; i >= 0; i--) step("scan", 1'b0, 1'b1, scan_pat[i], 1'b1);
        check_eq("scan_0110", 32'(bus.bCount), 32'h6);
        check_eq("scan_out_0110", 32'(bus.bScanOut), 32'd0);

        step("resume", 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("resume_0111", 32'(bus.bCount), 32'h7);

        for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 1'($urandom), 1'b0);
        check_eq("hold_0111", 32'(bus.bCount), 32'h7);

        // Drive all-ones through the chain, then wrap
        for (int i = 0; i < 4; i++) step("scan_ones", 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("scan_ones", 32'(bus.bCount), 32'hf);
        check_eq("scan_out_one", 32'(bus.bScanOut), 32'd1);
        step("wrap", 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("wrap_zero", 32'(bus.bCount), 32'd0);
`ifdef UP_COUNTER_SCAN_WRAP_EN
        check_eq("wrap_flag", 32'(bus.bWrap), 32'd1);
`endif
        step("post_wrap", 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("post_wrap_one", 32'(bus.bCount), 32'd1);

        step("rst_scan", 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("rst_over_scan", 32'(bus.bCount), 32'd0);

        // Randomized traffic, scan biased to make wraps and mixed patterns likely
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) == 0),
                 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
